// File: rtl/zrle_pkg.sv
// Shared ZRLE constants and state encoding, used by both the code buffer
// (compression side) and the code unpacker (decompression side).
package zrle_pkg;

  localparam int WORD_W     = 64;
  localparam int WIN_W      = 68;
  localparam int BUF_W      = 144;
  localparam int MAX_WORDS  = 8;
  localparam int RAW_SIZE   = 513;
  localparam int SIZE_W     = 11;

  localparam int CNT_W      = 8;
  localparam int REM_W      = 10;
  localparam int GOT_W      = 4;
  localparam int BITS_W     = 7;
  localparam int WORD_SH    = $clog2(WORD_W);
  localparam int FILL_LIMIT = BUF_W - WORD_W;
  localparam int BLOCK_BITS = MAX_WORDS * WORD_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/zrle_bitbuf.sv
// MSB-aligned bit buffer: drops consumed bits off the top and appends a new
// word directly below the bits still held, all in one cycle.
module zrle_bitbuf
  import zrle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BITS_W-1:0] shift,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              clear,
  output logic [WIN_W-1:0]  win,
  output logic [CNT_W-1:0]  cnt
);

  logic [BUF_W-1:0] bits;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] placed;
  logic [BUF_W-1:0] bits_n;
  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] cnt_n;

  always_comb begin
    shifted = bits << shift;
    cnt_s   = cnt - CNT_W'(shift);
    // The word lands right below the bits still valid after this cycle's shift.
    placed  = {word, {(BUF_W - WORD_W){1'b0}}} >> cnt_s;
    bits_n  = load ? (shifted | placed) : shifted;
    cnt_n   = load ? (cnt_s + CNT_W'(WORD_W)) : cnt_s;
    if (clear) begin
      bits_n = '0;
      cnt_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits <= '0;
      cnt  <= '0;
    end else begin
      bits <= bits_n;
      cnt  <= cnt_n;
    end
  end

  assign win = bits[BUF_W-1 -: WIN_W];

endmodule

// File: rtl/zrle_code_unpack.sv
// ZRLE code unpacker: takes a block size plus packed 64-bit code words and
// serves an MSB-aligned bit window to a variable-rate symbol decoder.
module zrle_code_unpack
  import zrle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SIZE_W-1:0] size_i,
  input  logic              size_valid_i,
  output logic              size_ready_o,
  input  logic [WORD_W-1:0] data_i,
  input  logic              d_valid_i,
  output logic              d_ready_o,
  output logic [WIN_W-1:0]  win_o,
  output logic [BITS_W-1:0] win_bits_o,
  output logic              win_valid_o,
  output logic              raw_o,
  input  logic [BITS_W-1:0] consume_i,
  input  logic              consume_valid_i,
  output logic              done_o,
  output logic              err_o
);

  function automatic logic [REM_W-1:0] clamp_min(input logic [REM_W-1:0] a,
                                                 input logic [REM_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  state_t            state, state_n;
  logic [REM_W-1:0]  rem_bits, rem_n;
  logic [GOT_W-1:0]  words_got, got_n;
  logic [GOT_W-1:0]  words_need, need_n;
  logic              raw, raw_n;
  logic              done, done_n;
  logic              err;
  logic              alive;

  logic [WIN_W-1:0]  buf_win;
  logic [CNT_W-1:0]  buf_cnt;

  logic [REM_W-1:0]  cnt_ext;
  logic [REM_W-1:0]  avail_lim;
  logic [REM_W-1:0]  need_lim;
  logic [REM_W-1:0]  size_rem;
  logic [BITS_W-1:0] win_bits;
  logic [BITS_W-1:0] consume_lim;
  logic [BITS_W-1:0] shift;
  logic [WIN_W-1:0]  win_mask;
  logic              win_valid;
  logic              d_ready;
  logic              size_ready;
  logic              over;
  logic              take;
  logic              accept;
  logic              size_acc;
  logic              last;
  logic              err_set;

  always_comb begin
    cnt_ext     = REM_W'(buf_cnt);
    avail_lim   = clamp_min(clamp_min(cnt_ext, rem_bits), REM_W'(WIN_W));
    win_bits    = avail_lim[BITS_W-1:0];
    need_lim    = clamp_min(rem_bits, REM_W'(WIN_W));
    win_valid   = (state == RUN) && (rem_bits != '0) && (cnt_ext >= need_lim);
    // Fetch depends only on registered state so it never loops through consume_i.
    d_ready     = (state == RUN) && (buf_cnt <= CNT_W'(FILL_LIMIT)) &&
                  (words_got < words_need);
    size_ready  = (state == IDLE) && alive;
    over        = consume_i > win_bits;
    consume_lim = over ? win_bits : consume_i;
    take        = consume_valid_i && win_valid;
    shift       = take ? consume_lim : '0;
    accept      = d_valid_i && d_ready;
    size_acc    = size_valid_i && size_ready;
    last        = take && (REM_W'(shift) == rem_bits);
    err_set     = consume_valid_i && (!win_valid || over);
    size_rem    = (size_i >= SIZE_W'(RAW_SIZE)) ? REM_W'(BLOCK_BITS)
                                                : size_i[REM_W-1:0];
    // Pad bits of the final word stay in the buffer but never reach the window.
    win_mask    = ~({WIN_W{1'b1}} >> win_bits);
  end

  always_comb begin
    state_n = state;
    rem_n   = rem_bits - REM_W'(shift);
    got_n   = words_got + GOT_W'(accept);
    need_n  = words_need;
    raw_n   = raw;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (size_acc) begin
          rem_n  = size_rem;
          need_n = GOT_W'((size_rem + REM_W'(WORD_W - 1)) >> WORD_SH);
          raw_n  = (size_i >= SIZE_W'(RAW_SIZE));
          got_n  = '0;
          if (size_rem == '0) begin
            done_n = 1'b1;
            raw_n  = 1'b0;
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (last) begin
          state_n = IDLE;
          rem_n   = '0;
          got_n   = '0;
          raw_n   = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rem_bits   <= '0;
      words_got  <= '0;
      words_need <= '0;
      raw        <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      alive      <= 1'b0;
    end else begin
      state      <= state_n;
      rem_bits   <= rem_n;
      words_got  <= got_n;
      words_need <= need_n;
      raw        <= raw_n;
      done       <= done_n;
      alive      <= 1'b1;
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  zrle_bitbuf u_bitbuf (
    .clk   (clk),
    .rst_n (rst_n),
    .shift (shift),
    .load  (accept),
    .word  (data_i),
    .clear (last),
    .win   (buf_win),
    .cnt   (buf_cnt)
  );

  assign size_ready_o = size_ready;
  assign d_ready_o    = d_ready;
  assign win_o        = buf_win & win_mask;
  assign win_bits_o   = win_bits;
  assign win_valid_o  = win_valid;
  assign raw_o        = raw;
  assign done_o       = done;
  assign err_o        = err;

endmodule

// File: tb/tb_zrle_code_unpack.sv
// Bench for zrle_code_unpack: a bit-stream model predicts every output each
// cycle, and directed blocks pin specific windows, errors and resets.
module tb_zrle_code_unpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] size_i = '0;
  logic        size_valid_i = 1'b0;
  logic        size_ready_o;
  logic [63:0] data_i = '0;
  logic        d_valid_i = 1'b0;
  logic        d_ready_o;
  logic [67:0] win_o;
  logic [6:0]  win_bits_o;
  logic        win_valid_o;
  logic        raw_o;
  logic [6:0]  consume_i = '0;
  logic        consume_valid_i = 1'b0;
  logic        done_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] wq [8];
  int          cq [$];
  logic [67:0] exp2 [3];
  int          wb2 [3];

  // Model: the block as a flat bit stream plus consumed/loaded positions.
  bit sm [0:639];
  int m_pos = 0, m_loaded = 0, m_total = 0, m_words = 0, m_need = 0;
  bit m_run = 0, m_raw = 0, m_done = 0, m_err = 0, m_alive = 0;

  zrle_code_unpack dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .size_i          (size_i),
    .size_valid_i    (size_valid_i),
    .size_ready_o    (size_ready_o),
    .data_i          (data_i),
    .d_valid_i       (d_valid_i),
    .d_ready_o       (d_ready_o),
    .win_o           (win_o),
    .win_bits_o      (win_bits_o),
    .win_valid_o     (win_valid_o),
    .raw_o           (raw_o),
    .consume_i       (consume_i),
    .consume_valid_i (consume_valid_i),
    .done_o          (done_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  task automatic chkv(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int m_wb();
    if (!m_run) return 0;
    return imin(imin(m_loaded - m_pos, m_total - m_pos), 68);
  endfunction

  function automatic bit m_wv();
    return m_run && (m_total - m_pos) > 0 &&
           (m_loaded - m_pos) >= imin(68, m_total - m_pos);
  endfunction

  function automatic bit m_dr();
    return m_run && (m_loaded - m_pos) <= 80 && m_words < m_need;
  endfunction

  function automatic logic [67:0] m_win();
    logic [67:0] w;
    int n;
    w = '0;
    n = m_wb();
    for (int i = 0; i < n; i++) w[67-i] = sm[m_pos+i];
    return w;
  endfunction

  // Model update on each clock edge or asynchronous reset.
  initial begin
    int  u_wb, u_c;
    bit  u_wv, u_dr;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pos = 0; m_loaded = 0; m_total = 0; m_words = 0; m_need = 0;
        m_run = 0; m_raw = 0; m_done = 0; m_err = 0; m_alive = 0;
      end else begin
        u_wb = m_wb();
        u_wv = m_wv();
        u_dr = m_dr();
        u_c  = 0;
        if (consume_valid_i) begin
          if (!u_wv || int'(consume_i) > u_wb) m_err = 1;
          if (u_wv) u_c = imin(int'(consume_i), u_wb);
        end
        m_pos += u_c;
        if (u_dr && d_valid_i) begin
          for (int i = 0; i < 64; i++) sm[m_loaded+i] = data_i[63-i];
          m_loaded += 64;
          m_words++;
        end
        m_done = 0;
        if (!m_run && m_alive && size_valid_i) begin
          m_total  = (size_i >= 11'd513) ? 512 : int'(size_i);
          m_raw    = (size_i >= 11'd513) && m_total > 0;
          m_need   = (m_total + 63) / 64;
          m_pos    = 0;
          m_loaded = 0;
          m_words  = 0;
          if (m_total == 0) m_done = 1;
          else m_run = 1;
        end else if (m_run && u_c > 0 && m_pos == m_total) begin
          m_run = 0; m_raw = 0; m_done = 1;
          m_pos = 0; m_loaded = 0; m_total = 0; m_words = 0;
        end
        m_alive = 1;
      end
    end
  end

  // Output comparison on every falling edge out of reset.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chkv("win_o", win_o, m_win());
        chki("win_bits_o", int'(win_bits_o), m_wb());
        chki("win_valid_o", int'(win_valid_o), int'(m_wv()));
        chki("d_ready_o", int'(d_ready_o), int'(m_dr()));
        chki("size_ready_o", int'(size_ready_o), int'(!m_run && m_alive));
        chki("raw_o", int'(raw_o), int'(m_raw));
        chki("done_o", int'(done_o), int'(m_done));
        chki("err_o", int'(err_o), int'(m_err));
      end
    end
  end

  task automatic idle_inputs();
    size_valid_i    = 1'b0;
    d_valid_i       = 1'b0;
    consume_valid_i = 1'b0;
    consume_i       = '0;
    data_i          = '0;
  endtask

  // mode 1: window top = word k; 2: literal windows; 3: raw block; 4: empty block
  task automatic run_block(input int size, input int first, input int nwords,
                           input int mode, input bit with_size, input int stop);
    int  idx, k, t;
    bit  sent, fin;
    idx  = first;
    k    = 0;
    t    = 0;
    sent = !with_size;
    fin  = 0;
    while (t < 400 && !fin) begin
      @(negedge clk);
      t++;
      if ((sent && done_o) || (stop > 0 && idx >= stop)) begin
        fin = 1;
      end else begin
        size_valid_i = !sent;
        size_i       = 11'(size);
        if (!sent && size_ready_o) sent = 1;
        d_valid_i = (idx < nwords);
        data_i    = (idx < nwords) ? wq[idx] : 64'd0;
        if (d_valid_i && d_ready_o) idx++;
        consume_valid_i = win_valid_o;
        if (cq.size() > 0 && win_valid_o) consume_i = 7'(cq.pop_front());
        else consume_i = (win_bits_o > 7'd64) ? 7'd64 : win_bits_o;
        if (win_valid_o) begin
          if (mode == 1) chkv("word_window", {4'b0, win_o[67:4]}, {4'b0, wq[k]});
          if (mode == 2 && k < 3) begin
            chkv("t2_window", win_o, exp2[k]);
            chki("t2_win_bits", int'(win_bits_o), wb2[k]);
          end
          if (mode == 3 && k == 0) chki("t3_raw_set", int'(raw_o), 1);
          k++;
        end
      end
    end
    chki("block_finished", int'(fin), 1);
    idle_inputs();
    if (stop == 0) begin
      chki("done_seen", int'(done_o), 1);
      if (mode == 2) chki("t2_bits_after", int'(win_bits_o), 0);
      if (mode == 3) begin
        chki("t3_words", idx, 8);
        chki("t3_raw_clear", int'(raw_o), 0);
      end
      if (mode == 4) begin
        chki("t4_consumes", k, 0);
        chki("t4_size_ready", int'(size_ready_o), 1);
      end
    end
  endtask

  initial begin
    logic [63:0] a, b;
    logic [67:0] e5;
    int idx, t;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chki("rst_size_ready", int'(size_ready_o), 0);
    chki("rst_win_valid", int'(win_valid_o), 0);
    chki("rst_d_ready", int'(d_ready_o), 0);
    chki("rst_done", int'(done_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chki("size_ready_after_rst", int'(size_ready_o), 1);

    // Full 512-bit block at 64 bits per consume.
    for (int i = 0; i < 8; i++) wq[i] = 64'h9E3779B97F4A7C15 * 64'(i + 1);
    run_block(512, 0, 8, 1, 1, 0);
    chki("t1_no_err", int'(err_o), 0);

    // 100-bit block over two words with uneven consumes.
    a = 64'h0123456789ABCDEF;
    b = 64'hFEDCBA9876543210;
    wq[0] = a;
    wq[1] = b;
    exp2[0] = {a, b[63:60]};
    exp2[1] = {a[56:0], b[63:53]};
    exp2[2] = {b[52:28], 43'd0};
    wb2[0] = 68; wb2[1] = 68; wb2[2] = 25;
    cq = '{7, 68, 25};
    run_block(100, 0, 2, 2, 1, 0);

    // Uncompressed block.
    for (int i = 0; i < 8; i++) wq[i] = ~(64'hC2B2AE3D27D4EB4F * 64'(i + 3));
    run_block(513, 0, 8, 3, 1, 0);

    // Empty block, then a one-word block right behind it.
    run_block(0, 0, 0, 4, 1, 0);
    wq[0] = 64'h8000_0000_0000_0001;
    run_block(64, 0, 1, 1, 1, 0);
    chki("t4_no_err", int'(err_o), 0);

    // Starved window: 20 bits buffered, 200 bits still owed.
    for (int i = 0; i < 8; i++) wq[i] = 64'h5851F42D4C957F2D ^ (64'h1111 << (i * 6));
    @(negedge clk);
    chki("t5_size_ready", int'(size_ready_o), 1);
    size_i = 11'd308;
    size_valid_i = 1'b1;
    @(negedge clk);
    size_valid_i = 1'b0;
    idx = 0;
    t = 0;
    while (idx < 2 && t < 20) begin
      d_valid_i = 1'b1;
      data_i = wq[idx];
      if (d_ready_o) idx++;
      @(negedge clk);
      t++;
    end
    d_valid_i = 1'b0;
    chki("t5_fill", idx, 2);
    chki("t5_valid_a", int'(win_valid_o), 1);
    consume_valid_i = 1'b1;
    consume_i = 7'd40;
    @(negedge clk);
    chki("t5_valid_b", int'(win_valid_o), 1);
    consume_i = 7'd68;
    @(negedge clk);
    consume_valid_i = 1'b0;
    e5 = {wq[1][19:0], 48'd0};
    chki("t5_stall_valid", int'(win_valid_o), 0);
    chki("t5_stall_bits", int'(win_bits_o), 20);
    chkv("t5_stall_win", win_o, e5);
    chki("t5_stall_d_ready", int'(d_ready_o), 1);
    @(negedge clk);
    consume_valid_i = 1'b1;
    consume_i = 7'd10;
    @(negedge clk);
    consume_valid_i = 1'b0;
    chki("t5_err_set", int'(err_o), 1);
    chki("t5_bits_kept", int'(win_bits_o), 20);
    chkv("t5_win_kept", win_o, e5);
    run_block(308, 2, 5, 0, 0, 0);
    chki("t5_err_sticky", int'(err_o), 1);

    // Reset in the middle of a block, then a clean one-word block.
    for (int i = 0; i < 8; i++) wq[i] = 64'hA5A5_0000_5A5A_FFFF + 64'(i * 977);
    run_block(512, 0, 3, 0, 1, 3);
    #2 rst_n = 1'b0;
    #1;
    chkv("arst_win_o", win_o, 68'd0);
    chki("arst_win_bits", int'(win_bits_o), 0);
    chki("arst_win_valid", int'(win_valid_o), 0);
    chki("arst_d_ready", int'(d_ready_o), 0);
    chki("arst_size_ready", int'(size_ready_o), 0);
    chki("arst_raw", int'(raw_o), 0);
    chki("arst_done", int'(done_o), 0);
    chki("arst_err", int'(err_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chki("t6_size_ready", int'(size_ready_o), 1);
    wq[0] = 64'hDEADBEEF0BADF00D;
    run_block(64, 0, 1, 1, 1, 0);
    chki("t6_no_err", int'(err_o), 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
